// File: rtl/arm_core_pkg.sv
// Shared types and helpers for the arm_core Thumb front end:
// condition codes, fetch FSM states, the suppressed-instruction NOP and flag indices.
package arm_core_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

  typedef enum logic {
    FETCH_FIRST  = 1'b0,
    FETCH_SECOND = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'hBF00_0000;

  // Bit positions inside the 5-bit apsr {N,Z,C,V,Q}
  localparam int APSR_N = 4;
  localparam int APSR_Z = 3;
  localparam int APSR_C = 2;
  localparam int APSR_V = 1;
  localparam int APSR_Q = 0;

  function automatic logic is_32b_prefix(input logic [15:0] hw);
    return (hw[15:11] == 5'b11101) || (hw[15:11] == 5'b11110) ||
           (hw[15:11] == 5'b11111);
  endfunction

  // nzcv is {N,Z,C,V}; Q never takes part in condition evaluation
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, gt;
    n  = nzcv[3];
    z  = nzcv[2];
    c  = nzcv[1];
    v  = nzcv[0];
    gt = !z && (n == v);
    case (cond_e'(cond))
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !(c && !z);
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return gt;
      COND_LE: return !gt;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/arm_core_if.sv
// Fetch unit: takes one halfword per cycle and assembles 16/32-bit Thumb instructions.
module arm_core_if
  import arm_core_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  inst_hw,
  output logic         inst_valid,
  output logic [31:0]  valid_inst,
  output fetch_state_e state
);

  fetch_state_e state_nx;
  logic [15:0]  first_q, first_nx;
  logic         valid_nx;
  logic [31:0]  inst_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH_FIRST;
      first_q    <= 16'h0;
      inst_valid <= 1'b0;
      valid_inst <= 32'h0;
    end else begin
      state      <= state_nx;
      first_q    <= first_nx;
      inst_valid <= valid_nx;
      valid_inst <= inst_nx;
    end
  end

  always_comb begin
    state_nx = state;
    first_nx = first_q;
    valid_nx = 1'b1;
    inst_nx  = {inst_hw, 16'h0};
    case (state)
      FETCH_FIRST: begin
        if (is_32b_prefix(inst_hw)) begin
          state_nx = FETCH_SECOND;
          first_nx = inst_hw;
          valid_nx = 1'b0;
          inst_nx  = 32'h0;
        end
      end
      FETCH_SECOND: begin
        state_nx = FETCH_FIRST;
        inst_nx  = {first_q, inst_hw};
      end
      default: state_nx = FETCH_FIRST;
    endcase
  end

endmodule

// File: rtl/arm_core_pre_dec.sv
// IT-aware pre-decoder: tracks ITSTATE, suppresses failing conditional instructions
// to NOP and extracts register addresses / immediate for the operand read.
module arm_core_pre_dec
  import arm_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] valid_inst,
  input  logic [3:0]  nzcv,
  output logic [31:0] inst_out,
  output logic        hint_or_exc,
  output logic [3:0]  cur_cond,
  output logic [7:0]  it_state,
  output logic        in_it_blk,
  output logic [3:0]  rn_addr,
  output logic [3:0]  rm_addr,
  output logic [3:0]  rd_addr,
  output logic [31:0] imm,
  output logic        imm_or_reg,
  output logic        shift_or_not,
  output logic        thumb_or_not
);

  logic [7:0] it_nx;
  logic       is_it;
  logic       pass;
  logic [4:0] op5;

  assign is_it     = inst_valid && (valid_inst[31:24] == 8'hBF) && (valid_inst[19:16] != 4'h0);
  assign in_it_blk = it_state[3:0] != 4'h0;
  assign cur_cond  = in_it_blk ? it_state[7:4] : COND_AL;
  assign pass      = cond_pass(cur_cond, nzcv);

  always_ff @(posedge clk) begin
    if (rst) it_state <= 8'h0;
    else     it_state <= it_nx;
  end

  always_comb begin
    it_nx       = it_state;
    inst_out    = 32'h0;
    hint_or_exc = 1'b0;
    if (is_it) begin
      it_nx       = valid_inst[23:16];
      inst_out    = NOP_INST;
      hint_or_exc = 1'b1;
    end else if (inst_valid) begin
      hint_or_exc = in_it_blk && !pass;
      inst_out    = hint_or_exc ? NOP_INST : valid_inst;
      // The last slot of a block is reached when the mask has shifted down to bit 3
      if (in_it_blk) begin
        if (it_state[2:0] == 3'b000) it_nx = 8'h0;
        else                         it_nx = {it_state[7:5], it_state[3:0], 1'b0};
      end
    end
  end

  assign op5          = inst_out[31:27];
  assign thumb_or_not = inst_out[15:0] == 16'h0;

  always_comb begin
    rn_addr      = 4'h0;
    rm_addr      = 4'h0;
    rd_addr      = 4'h0;
    imm          = 32'h0;
    imm_or_reg   = 1'b0;
    shift_or_not = 1'b0;
    if (thumb_or_not) begin
      if (op5 == 5'b00011) begin
        rd_addr    = {1'b0, inst_out[18:16]};
        rn_addr    = {1'b0, inst_out[21:19]};
        rm_addr    = {1'b0, inst_out[24:22]};
        imm_or_reg = inst_out[26];
        imm        = {29'h0, inst_out[24:22]};
      end else if (op5[4:2] == 3'b000) begin
        rd_addr      = {1'b0, inst_out[18:16]};
        rm_addr      = {1'b0, inst_out[21:19]};
        shift_or_not = 1'b1;
      end else if (op5[4:2] == 3'b001) begin
        rd_addr    = {1'b0, inst_out[26:24]};
        rn_addr    = {1'b0, inst_out[26:24]};
        imm_or_reg = 1'b1;
        imm        = {24'h0, inst_out[23:16]};
      end else if (inst_out[31:26] == 6'b010000) begin
        rd_addr = {1'b0, inst_out[18:16]};
        rn_addr = {1'b0, inst_out[18:16]};
        rm_addr = {1'b0, inst_out[21:19]};
      end
    end
  end

endmodule

// File: rtl/arm_core_reg_file.sv
// 16x32 register file: three combinational read ports, one synchronous write port.
module arm_core_reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr0,
  input  logic [3:0]  raddr1,
  input  logic [3:0]  raddr2,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [16];

  // r15 is the PC and is owned elsewhere, so writes to it are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
    end else if (we && (waddr != 4'hF)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata0 = regs[raddr0];
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/arm_core_xpsr_reg.sv
// APSR flag register {N,Z,C,V,Q} with independent per-flag write enables.
module arm_core_xpsr_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] apsr_we,
  input  logic [4:0] apsr_wdata,
  output logic [4:0] apsr
);

  always_ff @(posedge clk) begin
    if (rst) apsr <= 5'h0;
    else     apsr <= (apsr & ~apsr_we) | (apsr_wdata & apsr_we);
  end

endmodule

// File: rtl/arm_core.sv
// Thumb/Thumb-2 front end: fetch, IT-aware pre-decode, APSR and operand read.
module arm_core
  import arm_core_pkg::*;
(
  input  logic [15:0]  inst_hw,
  input  logic         rst,
  input  logic         clk,
  input  logic [4:0]   apsr_we,
  input  logic [4:0]   apsr_wdata,
  input  logic         rf_we,
  input  logic [3:0]   rf_waddr,
  input  logic [31:0]  rf_wdata,
  output logic         inst_valid,
  output logic [31:0]  valid_inst,
  output logic [31:0]  inst_out,
  output logic         hint_or_exc,
  output logic [3:0]   cur_cond,
  output logic [7:0]   it_state,
  output logic         in_it_blk,
  output logic [4:0]   apsr,
  output logic [3:0]   rn_addr,
  output logic [3:0]   rm_addr,
  output logic [3:0]   rd_addr,
  output logic [31:0]  rn_data,
  output logic [31:0]  rm_data,
  output logic [31:0]  rd_data,
  output logic         imm_or_reg,
  output logic         shift_or_not,
  output logic         thumb_or_not,
  output logic [31:0]  oprand1,
  output logic [31:0]  oprand2,
  output fetch_state_e fetch_state
);

  logic [31:0] imm;

  arm_core_if u_if (
    .clk        (clk),
    .rst        (rst),
    .inst_hw    (inst_hw),
    .inst_valid (inst_valid),
    .valid_inst (valid_inst),
    .state      (fetch_state)
  );

  arm_core_pre_dec u_pre_dec (
    .clk          (clk),
    .rst          (rst),
    .inst_valid   (inst_valid),
    .valid_inst   (valid_inst),
    .nzcv         (apsr[APSR_N:APSR_V]),
    .inst_out     (inst_out),
    .hint_or_exc  (hint_or_exc),
    .cur_cond     (cur_cond),
    .it_state     (it_state),
    .in_it_blk    (in_it_blk),
    .rn_addr      (rn_addr),
    .rm_addr      (rm_addr),
    .rd_addr      (rd_addr),
    .imm          (imm),
    .imm_or_reg   (imm_or_reg),
    .shift_or_not (shift_or_not),
    .thumb_or_not (thumb_or_not)
  );

  arm_core_xpsr_reg u_xpsr (
    .clk        (clk),
    .rst        (rst),
    .apsr_we    (apsr_we),
    .apsr_wdata (apsr_wdata),
    .apsr       (apsr)
  );

  arm_core_reg_file u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr0 (rn_addr),
    .raddr1 (rm_addr),
    .raddr2 (rd_addr),
    .rdata0 (rn_data),
    .rdata1 (rm_data),
    .rdata2 (rd_data)
  );

  assign oprand1 = rn_data;
  assign oprand2 = imm_or_reg ? imm : rm_data;

endmodule

// File: tb/tb_arm_core.sv
// Directed bench for arm_core: fetch assembly, IT blocks, condition evaluation,
// APSR timing, operand decode and reset behaviour, all against hand-computed values.
module tb_arm_core;
  import arm_core_pkg::*;

  logic [15:0]  inst_hw;
  logic         rst;
  logic         clk;
  logic [4:0]   apsr_we;
  logic [4:0]   apsr_wdata;
  logic         rf_we;
  logic [3:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic         inst_valid;
  logic [31:0]  valid_inst;
  logic [31:0]  inst_out;
  logic         hint_or_exc;
  logic [3:0]   cur_cond;
  logic [7:0]   it_state;
  logic         in_it_blk;
  logic [4:0]   apsr;
  logic [3:0]   rn_addr, rm_addr, rd_addr;
  logic [31:0]  rn_data, rm_data, rd_data;
  logic         imm_or_reg, shift_or_not, thumb_or_not;
  logic [31:0]  oprand1, oprand2;
  fetch_state_e fetch_state;

  int n_checks = 0;
  int n_fail   = 0;

  arm_core dut (
    .inst_hw      (inst_hw),
    .rst          (rst),
    .clk          (clk),
    .apsr_we      (apsr_we),
    .apsr_wdata   (apsr_wdata),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .inst_valid   (inst_valid),
    .valid_inst   (valid_inst),
    .inst_out     (inst_out),
    .hint_or_exc  (hint_or_exc),
    .cur_cond     (cur_cond),
    .it_state     (it_state),
    .in_it_blk    (in_it_blk),
    .apsr         (apsr),
    .rn_addr      (rn_addr),
    .rm_addr      (rm_addr),
    .rd_addr      (rd_addr),
    .rn_data      (rn_data),
    .rm_data      (rm_data),
    .rd_data      (rd_data),
    .imm_or_reg   (imm_or_reg),
    .shift_or_not (shift_or_not),
    .thumb_or_not (thumb_or_not),
    .oprand1      (oprand1),
    .oprand2      (oprand2),
    .fetch_state  (fetch_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one halfword (plus side-band writes) for one cycle; returns #1 after the edge
  task automatic step(input logic [15:0] hw, input logic [4:0] a_we, input logic [4:0] a_wd,
                      input logic r_we, input logic [3:0] r_addr, input logic [31:0] r_data);
    @(negedge clk);
    rst        = 1'b0;
    inst_hw    = hw;
    apsr_we    = a_we;
    apsr_wdata = a_wd;
    rf_we      = r_we;
    rf_waddr   = r_addr;
    rf_wdata   = r_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] hw);
    step(hw, 5'h0, 5'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    apsr_we = 5'h0;
    rf_we   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    inst_hw    = 16'h0;
    apsr_we    = 5'h0;
    apsr_wdata = 5'h0;
    rf_we      = 1'b0;
    rf_waddr   = 4'h0;
    rf_wdata   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_inst_valid", inst_valid, 0);
    check("rst_valid_inst", valid_inst, 0);
    check("rst_it_state", it_state, 0);
    check("rst_apsr", apsr, 0);
    check("rst_hint", hint_or_exc, 0);
    check("rst_inst_out", inst_out, 0);

    // plain 16-bit stream
    drive(16'h2001);
    check("s16_valid", inst_valid, 1);
    check("s16_inst0", valid_inst, 32'h2001_0000);
    check("s16_out0", inst_out, 32'h2001_0000);
    check("s16_hint0", hint_or_exc, 0);
    check("movi_rd", rd_addr, 0);
    check("movi_imm_or_reg", imm_or_reg, 1);
    check("movi_op2", oprand2, 32'h1);
    check("movi_cond", cur_cond, 4'hE);
    drive(16'h1888);
    check("s16_inst1", valid_inst, 32'h1888_0000);
    check("s16_hint1", hint_or_exc, 0);

    // 32-bit assembly
    drive(16'hF000);
    check("s32_half_valid", inst_valid, 0);
    check("s32_half_inst", valid_inst, 0);
    check("s32_half_out", inst_out, 0);
    drive(16'hB800);
    check("s32_valid", inst_valid, 1);
    check("s32_inst", valid_inst, 32'hF000_B800);
    check("s32_thumb", thumb_or_not, 0);
    check("s32_imm_or_reg", imm_or_reg, 0);

    // IT EQ with Z=0: the IT itself and its one instruction become NOPs
    drive(16'hBF08);
    check("it_eq_self_hint", hint_or_exc, 1);
    check("it_eq_self_out", inst_out, 32'hBF00_0000);
    drive(16'h2001);
    check("it_eq_state", it_state, 8'h08);
    check("it_eq_cond", cur_cond, 4'h0);
    check("it_eq_hint", hint_or_exc, 1);
    check("it_eq_out", inst_out, 32'hBF00_0000);
    drive(16'h1888);
    check("it_eq_after_state", it_state, 0);
    check("it_eq_after_hint", hint_or_exc, 0);
    check("it_eq_after_inblk", in_it_blk, 0);

    // ITTE EQ with Z=1
    step(16'h1888, 5'b01000, 5'b01000, 1'b0, 4'h0, 32'h0);
    check("apsr_z_set", apsr, 5'b01000);
    drive(16'hBF06);
    drive(16'h2001);
    check("itte_hint0", hint_or_exc, 0);
    check("itte_cond0", cur_cond, 4'h0);
    drive(16'h2002);
    check("itte_hint1", hint_or_exc, 0);
    check("itte_cond1", cur_cond, 4'h0);
    check("itte_state1", it_state, 8'h0C);
    drive(16'h2003);
    check("itte_hint2", hint_or_exc, 1);
    check("itte_cond2", cur_cond, 4'h1);
    check("itte_state2", it_state, 8'h18);
    drive(16'h1888);
    check("itte_done", it_state, 0);

    // IT AL never suppresses
    drive(16'hBFE8);
    drive(16'h2001);
    check("it_al_inblk", in_it_blk, 1);
    check("it_al_cond", cur_cond, 4'hE);
    check("it_al_hint", hint_or_exc, 0);
    check("it_al_out", inst_out, 32'h2001_0000);

    // N=1,V=1,Z=0: GE passes, LT fails
    step(16'hBFA8, 5'b11010, 5'b10010, 1'b0, 4'h0, 32'h0);
    check("apsr_nv", apsr, 5'b10010);
    drive(16'h2001);
    check("it_ge_cond", cur_cond, 4'hA);
    check("it_ge_hint", hint_or_exc, 0);
    drive(16'hBFB8);
    drive(16'h2001);
    check("it_lt_cond", cur_cond, 4'hB);
    check("it_lt_hint", hint_or_exc, 1);

    // ITT EQ: flag write during first instruction only affects the second
    drive(16'hBF04);
    drive(16'h2001);
    check("itt_hint0", hint_or_exc, 1);
    @(negedge clk);
    inst_hw    = 16'h2002;
    apsr_we    = 5'b01000;
    apsr_wdata = 5'b01000;
    #1;
    check("itt_same_cycle_hint", hint_or_exc, 1);
    check("itt_same_cycle_apsr", apsr, 5'b10010);
    @(posedge clk);
    #1;
    check("itt_state1", it_state, 8'h08);
    check("itt_hint1", hint_or_exc, 0);
    check("itt_out1", inst_out, 32'h2002_0000);
    check("itt_apsr", apsr, 5'b11010);

    // operand read
    step(16'h0000, 5'h0, 5'h0, 1'b1, 4'd1, 32'd5);
    drive(16'h1888);
    check("add_reg_rn", rn_addr, 1);
    check("add_reg_rm", rm_addr, 2);
    check("add_reg_op1", oprand1, 32'd5);
    check("add_reg_op2", oprand2, 32'd0);
    check("add_reg_imm_or_reg", imm_or_reg, 0);
    drive(16'h1D48);
    check("add_imm_imm_or_reg", imm_or_reg, 1);
    check("add_imm_op1", oprand1, 32'd5);
    check("add_imm_op2", oprand2, 32'd5);
    drive(16'h4048);
    check("alu_rn", rn_addr, 0);
    check("alu_rm", rm_addr, 1);
    check("alu_op2", oprand2, 32'd5);
    drive(16'h0048);
    check("lsl_shift", shift_or_not, 1);
    check("lsl_rm", rm_addr, 1);
    check("lsl_op2", oprand2, 32'd5);
    step(16'h0000, 5'h0, 5'h0, 1'b1, 4'd15, 32'hFFFF_FFFF);
    check("r15_write_rd", rd_data, 32'd0);

    // reset in the middle of an IT block and of a 32-bit instruction
    drive(16'hBF08);
    drive(16'hF000);
    check("mid_it_state", it_state, 8'h08);
    do_reset();
    check("reset_it_state", it_state, 0);
    check("reset_apsr", apsr, 0);
    check("reset_valid", inst_valid, 0);
    drive(16'h2001);
    check("reset_drop_half", valid_inst, 32'h2001_0000);
    check("reset_hint", hint_or_exc, 0);
    check("reset_rf", oprand1, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
